// File: rtl/point_pkg.sv
// Shared types for the point walker: channel FSM states and the default point layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package point_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } t_state;

    localparam int PNT_COORD_W = 8;
    localparam int PNT_W       = 2 * PNT_COORD_W;

    // Default point layout, x in the upper half.
    typedef struct packed {
        logic [PNT_COORD_W-1:0] x;
        logic [PNT_COORD_W-1:0] y;
    } t_point;

endpackage

// File: rtl/point_walker_ch.sv
// One point channel: walks a start point by (dx,dy) for cnt steps, then reports done.
// Latency: done_vld is visible cnt+1 cycles after the accepting edge (1 cycle for cnt=0).
// Backpressure: loads are accepted only in IDLE; DONE holds point and done_vld until done_rdy.
// Build option POINT_WALKER_SAT_EN: clamp each axis to [0, 2^W-1] instead of wrapping.
module point_walker_ch import point_pkg::*; #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld_vld,
    output logic           ld_rdy,
    input  logic [2*W-1:0] ld_pnt,
    input  logic [W-1:0]   ld_dx,
    input  logic [W-1:0]   ld_dy,
    input  logic [CW-1:0]  ld_cnt,
    output logic [2*W-1:0] pnt_o,
    output logic           busy,
    output logic           done_vld,
    input  logic           done_rdy
);

    t_state        state;
    t_state        state_nxt;
    logic [W-1:0]  x_q;
    logic [W-1:0]  y_q;
    logic [W-1:0]  dx_q;
    logic [W-1:0]  dy_q;
    logic [CW-1:0] rem_q;
    logic          load;

    // One axis step; the delta is two's complement so sign extension is implied.
    function automatic logic [W-1:0] step_axis(input logic [W-1:0] c, input logic [W-1:0] d);
`ifdef POINT_WALKER_SAT_EN
        logic signed [W+1:0] s;
        s = $signed({2'b00, c}) + $signed({{2{d[W-1]}}, d});
        if (s[W+1])
            return '0;
        else if (s[W])
            return '1;
        else
            return s[W-1:0];
`else
        return c + d;
`endif
    endfunction

    assign load     = (state == IDLE) && ld_vld;
    // ld_rdy is forced low while reset is held so nothing looks acceptable during reset.
    assign ld_rdy   = (state == IDLE) && rst;
    assign busy     = (state == RUN);
    assign done_vld = (state == DONE);
    assign pnt_o    = {x_q, y_q};

    // Next-state: a zero-length walk goes straight to DONE; the last step is the one with rem==1.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ld_vld) state_nxt = (ld_cnt == '0) ? DONE : RUN;
            RUN:     if (rem_q == CW'(1)) state_nxt = DONE;
            DONE:    if (done_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Datapath: capture on load, step every RUN cycle, hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q   <= '0;
            y_q   <= '0;
            dx_q  <= '0;
            dy_q  <= '0;
            rem_q <= '0;
        end else if (load) begin
            x_q   <= ld_pnt[2*W-1:W];
            y_q   <= ld_pnt[W-1:0];
            dx_q  <= ld_dx;
            dy_q  <= ld_dy;
            rem_q <= ld_cnt;
        end else if (state == RUN) begin
            x_q   <= step_axis(x_q, dx_q);
            y_q   <= step_axis(y_q, dy_q);
            rem_q <= rem_q - CW'(1);
        end
    end

endmodule

// File: rtl/point_walker.sv
// N independent point walkers side by side; channels share only clock and reset.
// Latency: per channel, done_vld cnt+1 cycles after the accepting edge.
// Backpressure: per channel ld_vld/ld_rdy and done_vld/done_rdy handshakes.
// Build option POINT_WALKER_SAT_EN: saturating coordinates instead of wrapping.
module point_walker import point_pkg::*; #(
    parameter int N  = 2,
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     ld_vld,
    output logic [N-1:0]     ld_rdy,
    input  logic [N*2*W-1:0] ld_pnt,
    input  logic [N*W-1:0]   ld_dx,
    input  logic [N*W-1:0]   ld_dy,
    input  logic [N*CW-1:0]  ld_cnt,
    output logic [N*2*W-1:0] pnt_o,
    output logic [N-1:0]     busy,
    output logic [N-1:0]     done_vld,
    input  logic [N-1:0]     done_rdy
);

    for (genvar g = 0; g < N; g++) begin : g_ch
        point_walker_ch #(
            .W  (W),
            .CW (CW)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .ld_vld   (ld_vld[g]),
            .ld_rdy   (ld_rdy[g]),
            .ld_pnt   (ld_pnt[g*2*W +: 2*W]),
            .ld_dx    (ld_dx[g*W +: W]),
            .ld_dy    (ld_dy[g*W +: W]),
            .ld_cnt   (ld_cnt[g*CW +: CW]),
            .pnt_o    (pnt_o[g*2*W +: 2*W]),
            .busy     (busy[g]),
            .done_vld (done_vld[g]),
            .done_rdy (done_rdy[g])
        );
    end

endmodule

// File: tb/tb_point_walker.sv
// Bench for point_walker: directed walks with literal expectations plus a random phase,
// all cycles also checked against a trajectory model precomputed at each accepted load.
module tb_point_walker;

    localparam int N    = 2;
    localparam int W    = 8;
    localparam int CW   = 8;
    localparam int MASK = (1 << W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     ld_vld = '0;
    logic [N-1:0]     ld_rdy;
    logic [N*2*W-1:0] ld_pnt = '0;
    logic [N*W-1:0]   ld_dx = '0;
    logic [N*W-1:0]   ld_dy = '0;
    logic [N*CW-1:0]  ld_cnt = '0;
    logic [N*2*W-1:0] pnt_o;
    logic [N-1:0]     busy;
    logic [N-1:0]     done_vld;
    logic [N-1:0]     done_rdy = '0;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    point_walker #(.N(N), .W(W), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_vld   (ld_vld),
        .ld_rdy   (ld_rdy),
        .ld_pnt   (ld_pnt),
        .ld_dx    (ld_dx),
        .ld_dy    (ld_dy),
        .ld_cnt   (ld_cnt),
        .pnt_o    (pnt_o),
        .busy     (busy),
        .done_vld (done_vld),
        .done_rdy (done_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic for one axis step.
    function automatic int stp(input int c, input int d);
        int s;
        s = c + d;
`ifdef POINT_WALKER_SAT_EN
        if (s < 0) s = 0;
        else if (s > MASK) s = MASK;
`else
        s = s & MASK;
`endif
        return s;
    endfunction

    // Model: on each accepted load the whole trajectory is written out; the channel then
    // shows trajectory entry pos while pos<len, then the final point with done until taken.
    int traj_x [N][256];
    int traj_y [N][256];
    int pos    [N];
    int len    [N];
    int fin_x  [N];
    int fin_y  [N];
    bit pend   [N];

    initial begin
        for (int c = 0; c < N; c++) begin
            pos[c] = 0; len[c] = 0; fin_x[c] = 0; fin_y[c] = 0; pend[c] = 1'b0;
        end
        forever begin
            @(posedge clk or negedge rst);
            for (int c = 0; c < N; c++) begin
                if (!rst) begin
                    pos[c] = 0; len[c] = 0; fin_x[c] = 0; fin_y[c] = 0; pend[c] = 1'b0;
                end else if (pos[c] < len[c]) begin
                    pos[c]++;
                end else if (pend[c]) begin
                    if (done_rdy[c]) pend[c] = 1'b0;
                end else if (ld_vld[c]) begin
                    logic [2*W-1:0]      p;
                    logic signed [W-1:0] sdx;
                    logic signed [W-1:0] sdy;
                    int cx, cy, n;
                    p   = ld_pnt[c*2*W +: 2*W];
                    sdx = ld_dx[c*W +: W];
                    sdy = ld_dy[c*W +: W];
                    n   = int'(ld_cnt[c*CW +: CW]);
                    cx  = int'(p[2*W-1:W]);
                    cy  = int'(p[W-1:0]);
                    for (int k = 0; k < n; k++) begin
                        traj_x[c][k] = cx;
                        traj_y[c][k] = cy;
                        cx = stp(cx, int'(sdx));
                        cy = stp(cy, int'(sdy));
                    end
                    fin_x[c] = cx; fin_y[c] = cy;
                    len[c] = n; pos[c] = 0; pend[c] = 1'b1;
                end
            end
        end
    end

    // Every falling edge: compare all channel outputs with the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int c = 0; c < N; c++) begin
                    int  ex, ey;
                    bit  e_busy, e_done, e_rdy;
                    e_busy = pos[c] < len[c];
                    e_done = !e_busy && pend[c];
                    e_rdy  = !e_busy && !pend[c] && rst;
                    ex = e_busy ? traj_x[c][pos[c]] : fin_x[c];
                    ey = e_busy ? traj_y[c][pos[c]] : fin_y[c];
                    chk($sformatf("model_pnt[%0d]", c), 32'(pnt_o[c*2*W +: 2*W]),
                        32'((ex << W) | ey));
                    chk($sformatf("model_busy[%0d]", c), 32'(busy[c]), 32'(e_busy));
                    chk($sformatf("model_done[%0d]", c), 32'(done_vld[c]), 32'(e_done));
                    chk($sformatf("model_rdy[%0d]", c), 32'(ld_rdy[c]), 32'(e_rdy));
                end
            end
        end
    end

    task automatic setld(input int c, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] dx, input logic [7:0] dy, input logic [7:0] cnt);
        ld_pnt[c*2*W +: 2*W] = {x, y};
        ld_dx[c*W +: W]      = dx;
        ld_dy[c*W +: W]      = dy;
        ld_cnt[c*CW +: CW]   = cnt;
        ld_vld[c]            = 1'b1;
    endtask

    // Load, then wait until the walk should be done (cnt+1 falling edges).
    task automatic walk(input int c, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] dx, input logic [7:0] dy, input logic [7:0] cnt);
        setld(c, x, y, dx, dy, cnt);
        @(negedge clk);
        ld_vld[c] = 1'b0;
        for (int i = 0; i < int'(cnt); i++) @(negedge clk);
        chk("walk_done", 32'(done_vld[c]), 32'd1);
    endtask

    task automatic release_ch(input int c);
        done_rdy[c] = 1'b1;
        @(negedge clk);
        done_rdy[c] = 1'b0;
    endtask

    initial begin
        // Reset state.
        #2;
        chk("rst_pnt",  32'(pnt_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done_vld), 32'd0);
        chk("rst_rdy",  32'(ld_rdy), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", 32'(ld_rdy), 32'h3);

        // Diagonal walk of three steps.
        setld(0, 8'h00, 8'h00, 8'h01, 8'h01, 8'd3);
        @(negedge clk); ld_vld[0] = 1'b0;
        chk("diag_busy1", 32'(busy[0]), 32'd1);
        @(negedge clk);
        chk("diag_p1", 32'(pnt_o[15:0]), 32'h0101);
        @(negedge clk);
        chk("diag_p2", 32'(pnt_o[15:0]), 32'h0202);
        chk("diag_busy3", 32'(busy[0]), 32'd1);
        @(negedge clk);
        chk("diag_done", 32'(done_vld[0]), 32'd1);
        chk("diag_p3", 32'(pnt_o[15:0]), 32'h0303);
        release_ch(0);
        chk("hold_after_done", 32'(pnt_o[15:0]), 32'h0303);

        // Negative deltas and wrap/saturate corner.
        walk(0, 8'hff, 8'hff, 8'hff, 8'hff, 8'd2);
        chk("neg_final", 32'(pnt_o[15:0]), 32'hfdfd);
        release_ch(0);
        walk(0, 8'hff, 8'h00, 8'h01, 8'hff, 8'd1);
`ifdef POINT_WALKER_SAT_EN
        chk("edge_final", 32'(pnt_o[15:0]), 32'hff00);
`else
        chk("edge_final", 32'(pnt_o[15:0]), 32'h00ff);
`endif
        release_ch(0);

        // Zero-length walk.
        walk(0, 8'h12, 8'h34, 8'h05, 8'h05, 8'd0);
        chk("zero_pnt",  32'(pnt_o[15:0]), 32'h1234);
        chk("zero_busy", 32'(busy[0]), 32'd0);

        // Stall in DONE with a load pending: nothing may change.
        setld(0, 8'h77, 8'h77, 8'h01, 8'h01, 8'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_done", 32'(done_vld[0]), 32'd1);
            chk("stall_rdy",  32'(ld_rdy[0]), 32'd0);
            chk("stall_pnt",  32'(pnt_o[15:0]), 32'h1234);
        end
        ld_vld[0] = 1'b0;
        done_rdy[0] = 1'b1;
        @(negedge clk);
        done_rdy[0] = 1'b0;
        chk("stall_release_rdy", 32'(ld_rdy[0]), 32'd1);
        chk("stall_release_done", 32'(done_vld[0]), 32'd0);

        // Two channels loaded together with different lengths.
        setld(0, 8'h10, 8'h20, 8'h03, 8'hfe, 8'd10);
        setld(1, 8'h50, 8'h60, 8'h01, 8'h01, 8'd2);
        @(negedge clk); ld_vld = '0;
        @(negedge clk); @(negedge clk);
        chk("par_ch1_done", 32'(done_vld[1]), 32'd1);
        chk("par_ch1_pnt",  32'(pnt_o[31:16]), 32'h5262);
        chk("par_ch0_busy", 32'(busy[0]), 32'd1);
        release_ch(1);
        for (int i = 0; i < 7; i++) @(negedge clk);
        chk("par_ch0_done", 32'(done_vld[0]), 32'd1);
        chk("par_ch0_pnt",  32'(pnt_o[15:0]), 32'h2e0c);
        release_ch(0);

        // Full-range count.
        walk(0, 8'h00, 8'h00, 8'h01, 8'h00, 8'd255);
        chk("full_pnt", 32'(pnt_o[15:0]), 32'hff00);
        release_ch(0);

        // Asynchronous reset in the middle of a walk.
        setld(0, 8'h00, 8'h00, 8'h01, 8'h01, 8'd10);
        @(negedge clk); ld_vld[0] = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_pnt",  32'(pnt_o), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done_vld), 32'd0);
        chk("arst_rdy",  32'(ld_rdy), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 15; i++) @(negedge clk);
        chk("arst_no_done", 32'(done_vld), 32'd0);

        // Random traffic checked by the model.
        for (int t = 0; t < 1500; t++) begin
            for (int c = 0; c < N; c++) begin
                ld_vld[c]            = ($urandom_range(0, 2) == 0);
                ld_pnt[c*2*W +: 2*W] = 16'($urandom);
                ld_dx[c*W +: W]      = 8'($urandom);
                ld_dy[c*W +: W]      = 8'($urandom);
                ld_cnt[c*CW +: CW]   = ($urandom_range(0, 15) == 0) ? 8'($urandom)
                                                                    : 8'($urandom_range(0, 5));
                done_rdy[c]          = ($urandom_range(0, 1) == 0);
            end
            @(negedge clk);
        end
        ld_vld = '0;
        done_rdy = '0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/point_walker.md
POINT_WALKER -- requirements
Module: point_walker

Interface
REQ-001 Parameter N, default 2: number of independent point channels (1..16).
REQ-002 Parameter W, default 8: coordinate width; x and y are unsigned W bits.
REQ-003 Parameter CW, default 8: step-count width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (asserts without clk, releases synchronously to clk).
REQ-006 ld_vld  input  N  per-channel load request.
REQ-007 ld_rdy  output  N  per-channel load accept; high only in IDLE.
REQ-008 ld_pnt  input  N x 2W  start point per channel, packed {x,y}, x in MSBs.
REQ-009 ld_dx, ld_dy  input  N x W each  signed two's-complement per-step delta.
REQ-010 ld_cnt  input  N x CW  number of steps to walk.
REQ-011 pnt_o  output  N x 2W  current point per channel, packed {x,y}, registered.
REQ-012 busy  output  N  high while the channel is in RUN.
REQ-013 done_vld  output  N  walk finished; held until accepted.
REQ-014 done_rdy  input  N  consumer accepts the finished walk.

Function
REQ-015 Each channel shall run its own FSM: IDLE, RUN, DONE; channels shall never interact.
REQ-016 IDLE: ld_rdy=1; ld_vld=1 shall capture ld_pnt into pnt_o, ld_dx/ld_dy into delta registers, ld_cnt into remaining counter rem.
REQ-017 Load with ld_cnt>0 shall go IDLE->RUN; load with ld_cnt=0 shall go IDLE->DONE with pnt_o = ld_pnt.
REQ-018 RUN: every cycle, x += dx, y += dy, rem -= 1; rem=1 at the step edge shall go RUN->DONE.
REQ-019 done_vld shall rise exactly ld_cnt+1 cycles after the accepting edge (1 cycle for ld_cnt=0).
REQ-020 DONE: done_vld=1, pnt_o frozen; done_rdy=1 shall go DONE->IDLE; done_rdy without done_vld shall be ignored.
REQ-021 ld_vld outside IDLE shall be ignored and not queued; ld_rdy=0 in RUN and DONE.
REQ-022 Default arithmetic: x and y shall wrap modulo 2^W independently (e.g. W=8: 8'hff + 1 -> 8'h00, 8'h00 - 1 -> 8'hff).
REQ-023 Delta shall be sign-extended; dx=-1 (all ones) shall decrement.
REQ-024 pnt_o shall hold its value in IDLE after DONE->IDLE until the next load.
REQ-025 Full-range ld_cnt = 2^CW-1 shall perform exactly that many steps without counter overflow.

Reset
REQ-026 On rst low: every channel to IDLE, pnt_o=0, delta=0, rem=0, busy=0, done_vld=0, ld_rdy=1 (after release).
REQ-027 Reset mid-RUN or mid-DONE shall abort the walk with no done_vld pulse.
REQ-028 ld_rdy shall read 0 while rst is low.

Configuration
REQ-029 Macro POINT_WALKER_SAT_EN defined: coordinates shall saturate at 0 and 2^W-1 instead of wrapping (e.g. 8'hfe + 3 -> 8'hff; 8'h01 - 2 -> 8'h00), each axis independently.
REQ-030 Macro absent: wrap behaviour of REQ-022 only; no saturation logic shall be synthesised.

Structure
REQ-031 Shared package point_pkg shall hold the FSM state enum (IDLE, RUN, DONE), the default packed point typedef t_point (x,y, 8-bit) and its width constant.
REQ-032 One sub-module point_walker_ch shall implement a single channel (FSM, counter, adder/saturation); point_walker shall instantiate N copies via generate.

Verification
REQ-033 W=8: load {x=00,y=00}, dx=1, dy=1, cnt=3 -> busy 3 cycles, pnt_o 01/01, 02/02, 03/03, done_vld on 4th cycle with {03,03}.
REQ-034 Load {ff,ff}, dx=-1, dy=-1, cnt=2 -> final {fd,fd}; load {ff,00}, dx=1, dy=-1, cnt=1 -> {00,ff} without SAT_EN, {ff,00} with it.
REQ-035 cnt=0 load {12,34} -> done_vld next cycle, pnt_o {12,34}, busy never high.
REQ-036 Hold done_rdy=0 for 5 cycles in DONE with ld_vld=1 -> done_vld and pnt_o stable, ld_rdy=0, no reload; done_rdy=1 -> IDLE next cycle.
REQ-037 N=2: channel 0 cnt=10, channel 1 cnt=2 loaded same cycle -> channel 1 done at +3, channel 0 at +11, values independent.
REQ-038 Assert rst low asynchronously at step 5 of cnt=10 -> pnt_o=0, busy=0, done_vld=0 immediately; no done_vld after release.
